// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction-fetch (read-only) and data-memory ports.
// DM has priority; a saturating starvation counter forces an IF grant after STARVE_LIMIT DM wins.
module mem_port_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        misalign_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_done_q, if_done_d;
    logic        dm_done_q, dm_done_d;
    logic        misalign_q, misalign_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        misalign_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        grant_dm    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant_dm = dm_req && !(if_req && (starve_q == LIMIT));
                    owner_d  = grant_dm;
                    we_d     = grant_dm && dm_we;
                    addr_d   = grant_dm ? dm_addr : if_addr;
                    wdata_d  = grant_dm ? dm_wdata : 32'd0;
                    if (grant_dm && if_req) begin
                        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                    // Misaligned requests never touch memory and complete on the next cycle.
                    if (addr_d[1:0] != 2'b00) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                        if_done_d  = !grant_dm;
                        dm_done_d  = grant_dm;
                        if (!we_d) begin
                            if (grant_dm) begin
                                dm_rdata_d = 32'd0;
                            end else begin
                                if_rdata_d = 32'd0;
                            end
                        end
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = we_d;
                        mem_addr_d  = addr_d;
                        mem_wdata_d = wdata_d;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
                wait_d  = 3'd0;
            end
            ST_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    state_d   = ST_DONE;
                    if_done_d = !owner_q;
                    dm_done_d = owner_q;
                    if (!we_q) begin
                        if (owner_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            starve_q    <= 4'd0;
            wait_q      <= 3'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            misalign_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            misalign_q  <= misalign_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stalls are gated by reset so every output reads 0 while reset is held.
    assign if_stall     = reset & if_req & ~if_done_q;
    assign dm_stall     = reset & dm_req & ~dm_done_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign if_done      = if_done_q;
    assign dm_done      = dm_done_q;
    assign misalign_err = misalign_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
